// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the clock-enable generator and its channel dividers.
package clk_gen_pkg;

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} seq_state_e;

  // Width of the divide/phase fields carried in a channel config word.
  localparam int CFG_W = 8;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
  } ce_cfg_t;

  localparam int         LOCK_CNT_W   = 8;
  localparam logic [7:0] LOST_CNT_MAX = 8'd255;

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: free-running divider, shadow config applied on the
// period boundary, and strobe decode.
module clk_en_div
  import clk_gen_pkg::*;
#(
  parameter int DEF_DIV = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    run,
  input  logic    we,
  input  ce_cfg_t cfg,
  output logic    ce
);

  ce_cfg_t          cur, shadow;
  logic             pending;
  logic [CFG_W-1:0] count, strobe_at;
  logic             wrap, idle, apply;

  assign wrap      = (count == cur.div - 1'b1);
  assign idle      = !run || (cur.div == '0);
  // Swap config only where the next cycle starts a fresh period.
  assign apply     = pending && (idle || wrap);
  assign strobe_at = (cur.phase < cur.div) ? cur.phase : '0;
  assign ce        = run && (cur.div != '0) && (count == strobe_at);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur.div   <= CFG_W'(DEF_DIV);
      cur.phase <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      count     <= '0;
    end else begin
      if (idle || wrap) count <= '0;
      else              count <= count + 1'b1;
      if (apply) cur <= shadow;
      // A write landing on the apply cycle stays pending for the next boundary.
      if (we) begin
        shadow  <= cfg;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Lock-qualified reset sequencer plus NUM_CH programmable clock-enable channels
// running on the fabric clock.
module clk_en_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD    = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_locked,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [DIV_W-1:0]  i_cfg_phase,
  output logic [NUM_CH-1:0] o_ce,
  output logic              o_rst_out,
  output logic              o_ready,
  output logic [7:0]        o_lock_lost
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [LOCK_CNT_W-1:0] LOCK_TOP = LOCK_CNT_W'(LOCK_FILTER - 1);

  logic                  lock_meta, locked_s, stable;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  seq_state_e            state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  run;
  logic [NUM_CH-1:0]     ch_we;
  ce_cfg_t               wr_cfg;

  // Combinational so a single low locked_s sample drops stable immediately.
  assign stable = locked_s && (lock_cnt == LOCK_TOP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      lock_meta <= i_locked;
      locked_s  <= lock_meta;
      if (!locked_s)              lock_cnt <= '0;
      else if (lock_cnt != LOCK_TOP) lock_cnt <= lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      o_rst_out   <= 1'b1;
      o_ready     <= 1'b0;
      o_lock_lost <= '0;
    end else begin
      case (state)
        WAIT_LOCK: if (stable) state <= HOLD;
        HOLD: begin
          if (!stable) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            state     <= RUN;
            hold_cnt  <= '0;
            o_rst_out <= 1'b0;
            o_ready   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: if (!stable) begin
          state     <= WAIT_LOCK;
          o_rst_out <= 1'b1;
          o_ready   <= 1'b0;
          if (o_lock_lost != LOST_CNT_MAX) o_lock_lost <= o_lock_lost + 1'b1;
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  assign run          = (state == RUN);
  assign wr_cfg.div   = CFG_W'(i_cfg_div);
  assign wr_cfg.phase = CFG_W'(i_cfg_phase);

  // Out-of-range channel numbers match no decode slot and are dropped.
  always_comb begin
    ch_we = '0;
    for (int k = 0; k < NUM_CH; k++) ch_we[k] = i_cfg_we && (32'(i_cfg_ch) == k);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_en_div #(.DEF_DIV(DEF_DIV)) u_div (
      .clk   (i_clk),
      .reset (i_reset),
      .run   (run),
      .we    (ch_we[k]),
      .cfg   (wr_cfg),
      .ce    (o_ce[k])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: a per-edge reference model pushes expected
// outputs, a negedge monitor pops and compares.
module tb_clk_en_gen;
  localparam int NCH     = 4;
  localparam int DEF_DIV = 2;
  // Raw lock must be seen high for LOCK_FILTER + RST_HOLD samples; two more
  // newest samples are still inside the synchroniser.
  localparam int SEQ     = 2 + 16 + 8;

  logic       i_clk = 1'b0, i_reset = 1'b1, i_locked = 1'b0, i_cfg_we = 1'b0;
  logic [1:0] i_cfg_ch = '0;
  logic [7:0] i_cfg_div = '0, i_cfg_phase = '0;
  logic [3:0] o_ce;
  logic       o_rst_out, o_ready;
  logic [7:0] o_lock_lost;
  logic [2:0] ce3;
  logic       rst3, rdy3;
  logic [7:0] lost3;

  always #5 i_clk = ~i_clk;

  clk_en_gen #(.NUM_CH(4)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_locked(i_locked), .i_cfg_we(i_cfg_we),
    .i_cfg_ch(i_cfg_ch), .i_cfg_div(i_cfg_div), .i_cfg_phase(i_cfg_phase),
    .o_ce(o_ce), .o_rst_out(o_rst_out), .o_ready(o_ready), .o_lock_lost(o_lock_lost));

  // Three-channel copy: every write to channel 3 is out of range for it.
  clk_en_gen #(.NUM_CH(3)) u_dut3 (
    .i_clk(i_clk), .i_reset(i_reset), .i_locked(i_locked), .i_cfg_we(i_cfg_we),
    .i_cfg_ch(i_cfg_ch), .i_cfg_div(i_cfg_div), .i_cfg_phase(i_cfg_phase),
    .o_ce(ce3), .o_rst_out(rst3), .o_ready(rdy3), .o_lock_lost(lost3));

  typedef struct packed {
    logic [3:0] ce;
    logic       rst;
    logic       rdy;
    logic [7:0] lost;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: sequencer as a sliding window over lock samples, channels
  // as modular arithmetic from the cycle their current period began.
  logic [SEQ-1:0] hist = '0;
  bit   m_rdy = 0, prev_rdy;
  int   m_lost = 0, cyc = 0;
  int   cdiv[NCH], cph[NCH], org[NCH], sdiv[NCH], sph[NCH];
  bit   pend[NCH];

  initial forever begin
    exp_t e;
    @(posedge i_clk);
    cyc++;
    prev_rdy = m_rdy;
    if (i_reset) begin
      hist = '0; m_rdy = 0; m_lost = 0;
      for (int k = 0; k < NCH; k++) begin
        cdiv[k] = DEF_DIV; cph[k] = 0; pend[k] = 0; org[k] = 0;
      end
    end else begin
      hist  = {hist[SEQ-2:0], i_locked};
      m_rdy = &hist[SEQ-1:2];
      if (prev_rdy && !m_rdy && m_lost < 255) m_lost++;
      for (int k = 0; k < NCH; k++) begin
        int pos; bit app;
        pos = (prev_rdy && cdiv[k] != 0) ? (cyc - 1 - org[k]) % cdiv[k] : 0;
        app = pend[k] && (!prev_rdy || cdiv[k] == 0 || pos == cdiv[k] - 1);
        if (app) begin cdiv[k] = sdiv[k]; cph[k] = sph[k]; pend[k] = 0; end
        if (i_cfg_we && int'(i_cfg_ch) == k) begin
          sdiv[k] = int'(i_cfg_div); sph[k] = int'(i_cfg_phase); pend[k] = 1;
        end
        if (m_rdy && (!prev_rdy || app)) org[k] = cyc;
      end
    end
    e.ce = '0;
    for (int k = 0; k < NCH; k++)
      if (m_rdy && cdiv[k] != 0)
        e.ce[k] = (((cyc - org[k]) % cdiv[k]) == ((cph[k] < cdiv[k]) ? cph[k] : 0));
    e.rst  = !m_rdy;
    e.rdy  = m_rdy;
    e.lost = 8'(m_lost);
    exp_q.push_back(e);
  end

  initial forever begin
    exp_t e;
    @(negedge i_clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ce",        {4'b0, o_ce},      {4'b0, e.ce});
      check("rst_out",   {7'b0, o_rst_out}, {7'b0, e.rst});
      check("ready",     {7'b0, o_ready},   {7'b0, e.rdy});
      check("lock_lost", o_lock_lost,       e.lost);
      check("ce_3ch",    {5'b0, ce3},       {5'b0, e.ce[2:0]});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic write(input int ch, input int div, input int ph);
    i_cfg_we = 1'b1; i_cfg_ch = 2'(ch); i_cfg_div = 8'(div); i_cfg_phase = 8'(ph);
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic wait_ready(input logic lvl, input string name);
    int n = 0;
    while (o_ready !== lvl && n < 200) begin tick(); n++; end
    if (o_ready !== lvl) begin
      total++; bad++;
      $display("FAIL %s: ready=%b after %0d cycles, want %b", name, o_ready, n, lvl);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick(3);
    check("reset_rst_out", {7'b0, o_rst_out}, 8'd1);
    check("reset_ce", {4'b0, o_ce}, 8'd0);
    i_reset = 1'b0;
    tick(6);

    // Lock-up latency from the first edge that samples i_locked high.
    i_locked = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin tick(); n++; end
    check("lockup_latency", 8'(n), 8'd26);
    tick(9);

    write(1, 5, 3);  tick(20);
    write(1, 5, 9);  tick(15);
    write(1, 0, 0);  tick(12);
    write(3, 3, 1); write(2, 1, 0); write(0, 4, 2); tick(20);
    write(0, 6, 1); write(0, 7, 2); tick(20);
    write(2, 3, 2); tick(1); write(2, 5, 4); tick(20);

    // Reset in RUN with a pending write on channel 1.
    write(1, 7, 2);
    i_reset = 1'b1; tick();
    check("midreset_ready", {7'b0, o_ready}, 8'd0);
    check("midreset_lost", o_lock_lost, 8'd0);
    i_reset = 1'b0;
    // Glitch lands while the sequencer holds reset after lock.
    tick(19);
    i_locked = 1'b0; tick(); i_locked = 1'b1;
    wait_ready(1'b1, "relock_after_hold_glitch");
    check("hold_glitch_lost", o_lock_lost, 8'd0);
    tick(12);

    i_locked = 1'b0; tick(); i_locked = 1'b1;
    wait_ready(1'b0, "run_glitch_drop");
    check("run_glitch_lost", o_lock_lost, 8'd1);
    wait_ready(1'b1, "relock_after_run_glitch");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        write(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
      else tick();
      if ($urandom_range(0, 99) == 0) begin
        i_locked = 1'b0; tick(); i_locked = 1'b1;
      end
    end

    for (int i = 0; i < 300; i++) begin
      wait_ready(1'b1, "sat_relock");
      i_locked = 1'b0; tick(); i_locked = 1'b1;
      wait_ready(1'b0, "sat_drop");
    end
    wait_ready(1'b1, "sat_final_relock");
    check("lost_saturated", o_lock_lost, 8'd255);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
